fault_supervisor: RTL and testbench
===================================

# fault_supervisor

Parametrised protection/fault supervisor on the Wishbone peripheral bus. It monitors NUM_FAULTS external comparator/E-stop lines and a keyed watchdog, and immediately forces the PWM disable line on any fault. Per channel it adds input synchronisation, a programmable glitch filter and selectable polarity. It also provides write-1-to-clear sticky latches, per-source interrupt enables and first-fault capture. It replaces the fixed four-input protection block and sits between the board fault comparators and the PWM peripheral's disable input.

## Interface
Parameters:
- NUM_FAULTS, 4: external fault channels, 1..15; the watchdog is source index NUM_FAULTS.
- ADDR_WIDTH, 8: Wishbone byte-address width.
- FILTER_WIDTH, 8: width of the glitch-filter count register and per-channel counters.
- FILTER_DEFAULT, 3: reset value of FILTER.
- WATCHDOG_DEFAULT, 50_000_000: reset value of WDT_TIMEOUT (1 s at 50 MHz).
- WDT_KEY, 32'h5A5A_A5A5: value that kicks the watchdog.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- wb_addr  in  ADDR_WIDTH  byte address; only [7:2] is decoded.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- wb_we  in  1  write enable.
- wb_sel  in  4  ignored; all accesses are full-word.
- wb_stb  in  1  strobe.
- wb_ack  out  1  acknowledge.
- fault_in  in  NUM_FAULTS  raw asynchronous fault lines.
- pwm_disable  out  1  high while any fault is live or latched.
- irq  out  1  level interrupt.

## Operation
Source vector S is NUM_FAULTS+1 bits wide: bits [NUM_FAULTS-1:0] are the external channels; bit NUM_FAULTS is the watchdog.

Registers (word offsets; bits above S width read 0):
- 0x00 STATUS, RO: live = filt & ENABLE; the watchdog bit is wdt_expired & ENABLE.
- 0x04 ENABLE, RW: reset all ones. A disabled watchdog holds its counter at 0 and its expired flag at 0.
- 0x08 POLARITY, RW: reset 0. A 1 marks the channel as active-low. No watchdog bit.
- 0x0C LATCH: read returns the sticky bits. Write-1-to-clear.
- 0x10 FILTER, RW: FILTER_WIDTH bits; applies to all channels.
- 0x14 WDT_TIMEOUT, RW: writing it also restarts the watchdog counter.
- 0x18 WDT_KICK, WO: writing WDT_KEY sets counter=0 and expired=0. Writing any other value sets LATCH[NUM_FAULTS] directly (bad-key fault), even when the watchdog is disabled.
- 0x1C IRQ_EN, RW: reset 0.
- 0x20 FIRST_FAULT, RO: [3:0] = source index, [31] = valid.
- Unmapped addresses: reads return 0; writes are ignored.

Per-channel filter:
- Input chain: x = fault_in ^ POLARITY → 2-flop synchroniser → sync.
- Counter cnt (reset 0), updated each edge:
  - sync != filt and cnt >= FILTER: filt <= sync, cnt <= 0.
  - sync != filt otherwise: cnt <= cnt+1.
  - sync == filt: cnt <= 0.
- FILTER=0 means no filtering.
- Deassertion is filtered the same way.
- Changing FILTER mid-count takes effect on the next compare.

Latching, outputs and first-fault capture:
- Each edge: LATCH <= (LATCH & ~clr) | live, where clr is the W1C mask from a bus write this cycle. When set and clear coincide, set wins.
- pwm_disable = |LATCH | |live (combinational).
- irq registered: irq <= |(LATCH & IRQ_EN).
- FIRST_FAULT captures the lowest set index of the latch set-vector on the first edge any latch bit sets while valid=0. It clears (valid=0, index 0) when LATCH becomes all zero.

Watchdog:
- If enabled: when counter >= WDT_TIMEOUT, expired <= 1 and counter holds; otherwise counter increments.
- WDT_TIMEOUT=0 expires on the first enabled edge.

Wishbone:
- wb_ack <= wb_stb & !wb_ack, giving a one-cycle pulse. The minimum access takes 2 cycles, with no back-to-back ack.
- Writes take effect and read data is loaded on the edge that raises wb_ack.

## Timing
- Reset values: wb_ack=0, wb_dat_o=0, irq=0, pwm_disable=0; all filt, cnt, LATCH, counters and FIRST_FAULT are 0.
- Reset is asynchronous; assertion mid-access drops wb_ack immediately.
- Fault latency: fault_in changes before edge 0.
  - Sync output at edge 1; filt at edge 2+FILTER.
  - STATUS and pwm_disable high after edge 2+FILTER.
  - LATCH bit at edge 3+FILTER; irq at edge 4+FILTER.
- Glitch rejection: a pulse shorter than FILTER+1 sampled cycles never sets filt.
- Watchdog: after a kick at edge k, expired sets at edge k+WDT_TIMEOUT+1. pwm_disable follows combinationally after that edge.
- A W1C write of a still-live source leaves the bit set.
- Kick and expiry on the same edge: the kick wins.

## Test plan
- FILTER=3, pulse fault_in[0] high for 3 cycles → STATUS, LATCH, pwm_disable stay 0. Hold for 4 cycles → pwm_disable rises after edge 5; LATCH=0x1 at edge 6.
- POLARITY[2]=1, fault_in[2]=0, FILTER=0 → STATUS=0x4 and pwm_disable=1 after edge 2. Set ENABLE[2]=0 → STATUS=0; LATCH stays 0x4 until a W1C of 0x4 is written.
- Faults 3 then 1 asserted 10 cycles apart → FIRST_FAULT=0x8000_0003. Clear LATCH with 0x1F after the inputs drop → FIRST_FAULT=0.
- WDT_TIMEOUT=100, kick with 0x5A5A_A5A5 every 90 cycles → no fault. Stop kicking → LATCH[4] set, irq=1 with IRQ_EN=0x10.
- Write 0x1234 to WDT_KICK → LATCH=0x10 and pwm_disable=1 on the following edge.
- Assert rst_n low during a held fault and a pending ack → all outputs 0 immediately. After release, the fault relatches at edge 3+FILTER.

Source files
------------

// File: rtl/fault_supervisor.sv
// Protection supervisor: synchronised, glitch-filtered fault channels plus a keyed
// watchdog drive an immediate PWM disable, sticky latches, IRQ and first-fault capture.

module fault_supervisor_chan #(
   parameter int FILTER_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    fault_raw,
   input  logic                    polarity,
   input  logic [FILTER_WIDTH-1:0] filter,
   output logic                    filt
);
   logic [1:0]              sync_q;
   logic [FILTER_WIDTH-1:0] cnt;
   logic                    sync;

   assign sync = sync_q[1];

   // Both edges are filtered: filt only follows sync after FILTER+1 agreeing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         cnt    <= '0;
         filt   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], fault_raw ^ polarity};
         if (sync != filt) begin
            if (cnt >= filter) begin
               filt <= sync;
               cnt  <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end
endmodule

module fault_supervisor #(
   parameter int          NUM_FAULTS       = 4,
   parameter int          ADDR_WIDTH       = 8,
   parameter int          FILTER_WIDTH     = 8,
   parameter int          FILTER_DEFAULT   = 3,
   parameter int unsigned WATCHDOG_DEFAULT = 50_000_000,
   parameter logic [31:0] WDT_KEY          = 32'h5A5A_A5A5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [31:0]           wb_dat_i,
   output logic [31:0]           wb_dat_o,
   input  logic                  wb_we,
   input  logic [3:0]            wb_sel,
   input  logic                  wb_stb,
   output logic                  wb_ack,
   input  logic [NUM_FAULTS-1:0] fault_in,
   output logic                  pwm_disable,
   output logic                  irq
);
   localparam int SW = NUM_FAULTS + 1;

   localparam logic [5:0] A_STATUS = 6'h00;
   localparam logic [5:0] A_ENABLE = 6'h01;
   localparam logic [5:0] A_POL    = 6'h02;
   localparam logic [5:0] A_LATCH  = 6'h03;
   localparam logic [5:0] A_FILTER = 6'h04;
   localparam logic [5:0] A_WDT_TO = 6'h05;
   localparam logic [5:0] A_KICK   = 6'h06;
   localparam logic [5:0] A_IRQ_EN = 6'h07;
   localparam logic [5:0] A_FIRST  = 6'h08;

   logic [SW-1:0]           enable_q, latch_q, irq_en_q;
   logic [SW-1:0]           live, set_vec, clr, latch_nxt;
   logic [NUM_FAULTS-1:0]   pol_q, filt;
   logic [FILTER_WIDTH-1:0] filter_q;
   logic [31:0]             wdt_timeout_q, wdt_cnt_q, rd_data;
   logic                    wdt_expired_q;
   logic [3:0]              ff_idx_q, ff_idx_nxt;
   logic                    ff_valid_q;
   logic                    acc, wr, kick_ok, kick_bad, to_wr;
   logic [5:0]              reg_sel;
   logic                    unused_ok;

   assign unused_ok = ^{wb_sel, wb_addr};

   assign acc      = wb_stb & ~wb_ack;
   assign wr       = acc & wb_we;
   assign reg_sel  = wb_addr[7:2];
   assign kick_ok  = wr && (reg_sel == A_KICK) && (wb_dat_i == WDT_KEY);
   assign kick_bad = wr && (reg_sel == A_KICK) && (wb_dat_i != WDT_KEY);
   assign to_wr    = wr && (reg_sel == A_WDT_TO);
   assign clr      = (wr && (reg_sel == A_LATCH)) ? wb_dat_i[SW-1:0] : '0;

   genvar g;
   generate
      for (g = 0; g < NUM_FAULTS; g++) begin : g_chan
         fault_supervisor_chan #(.FILTER_WIDTH(FILTER_WIDTH)) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .fault_raw(fault_in[g]),
            .polarity (pol_q[g]),
            .filter   (filter_q),
            .filt     (filt[g])
         );
      end
   endgenerate

   assign live        = {wdt_expired_q & enable_q[NUM_FAULTS], filt & enable_q[NUM_FAULTS-1:0]};
   // A bad watchdog key latches the watchdog source without going through live.
   assign set_vec     = live | {kick_bad, {NUM_FAULTS{1'b0}}};
   assign latch_nxt   = (latch_q & ~clr) | set_vec;
   assign pwm_disable = (|latch_q) | (|live);

   always_comb begin
      ff_idx_nxt = '0;
      for (int i = SW - 1; i >= 0; i--) begin
         if (set_vec[i]) ff_idx_nxt = 4'(i);
      end
   end

   always_comb begin
      rd_data = '0;
      case (reg_sel)
         A_STATUS: rd_data[SW-1:0]           = live;
         A_ENABLE: rd_data[SW-1:0]           = enable_q;
         A_POL:    rd_data[NUM_FAULTS-1:0]   = pol_q;
         A_LATCH:  rd_data[SW-1:0]           = latch_q;
         A_FILTER: rd_data[FILTER_WIDTH-1:0] = filter_q;
         A_WDT_TO: rd_data                   = wdt_timeout_q;
         A_IRQ_EN: rd_data[SW-1:0]           = irq_en_q;
         A_FIRST:  rd_data                   = {ff_valid_q, 27'd0, ff_idx_q};
         default:  rd_data                   = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_ack        <= 1'b0;
         wb_dat_o      <= '0;
         enable_q      <= '1;
         pol_q         <= '0;
         irq_en_q      <= '0;
         filter_q      <= FILTER_WIDTH'(FILTER_DEFAULT);
         wdt_timeout_q <= 32'(WATCHDOG_DEFAULT);
      end else begin
         wb_ack <= wb_stb & ~wb_ack;
         if (acc) wb_dat_o <= rd_data;
         if (wr) begin
            case (reg_sel)
               A_ENABLE: enable_q      <= wb_dat_i[SW-1:0];
               A_POL:    pol_q         <= wb_dat_i[NUM_FAULTS-1:0];
               A_FILTER: filter_q      <= wb_dat_i[FILTER_WIDTH-1:0];
               A_WDT_TO: wdt_timeout_q <= wb_dat_i;
               A_IRQ_EN: irq_en_q      <= wb_dat_i[SW-1:0];
               default:  ;
            endcase
         end
      end
   end

   // First-fault capture re-arms only once every latch bit has been cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         latch_q    <= '0;
         irq        <= 1'b0;
         ff_idx_q   <= '0;
         ff_valid_q <= 1'b0;
      end else begin
         latch_q <= latch_nxt;
         irq     <= |(latch_q & irq_en_q);
         if (latch_nxt == '0) begin
            ff_idx_q   <= '0;
            ff_valid_q <= 1'b0;
         end else if (!ff_valid_q && (set_vec != '0)) begin
            ff_idx_q   <= ff_idx_nxt;
            ff_valid_q <= 1'b1;
         end
      end
   end

   // A kick outranks expiry on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdt_cnt_q     <= '0;
         wdt_expired_q <= 1'b0;
      end else if (!enable_q[NUM_FAULTS] || kick_ok) begin
         wdt_cnt_q     <= '0;
         wdt_expired_q <= 1'b0;
      end else if (to_wr) begin
         wdt_cnt_q <= '0;
      end else if (wdt_cnt_q >= wdt_timeout_q) begin
         wdt_expired_q <= 1'b1;
      end else begin
         wdt_cnt_q <= wdt_cnt_q + 32'd1;
      end
   end
endmodule

// File: tb/tb_fault_supervisor.sv
// Directed bench for fault_supervisor: bus reads push expectations into a queue that a
// negedge monitor pops on each wb_ack; timing-sensitive pins are checked directly.

module tb_fault_supervisor;
   localparam logic [7:0]  STATUS = 8'h00, ENABLE = 8'h04, POL = 8'h08, LATCH = 8'h0C;
   localparam logic [7:0]  FILTER = 8'h10, WDT_TO = 8'h14, KICK = 8'h18, IRQ_EN = 8'h1C;
   localparam logic [7:0]  FIRST = 8'h20;
   localparam logic [31:0] KEY = 32'h5A5A_A5A5;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [7:0]  wb_addr = '0;
   logic [31:0] wb_dat_i = '0, wb_dat_o;
   logic        wb_we = 1'b0, wb_stb = 1'b0, wb_ack;
   logic [3:0]  wb_sel = 4'hF;
   logic [3:0]  fault_in = '0;
   logic        pwm_disable, irq;
   logic        seen;

   int errors = 0, checks = 0;

   typedef struct {string name; logic [31:0] exp; bit rd;} exp_t;
   exp_t sb_q[$];

   fault_supervisor dut (
      .clk(clk), .rst_n(rst_n), .wb_addr(wb_addr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_we(wb_we), .wb_sel(wb_sel), .wb_stb(wb_stb), .wb_ack(wb_ack),
      .fault_in(fault_in), .pwm_disable(pwm_disable), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation still running, expected finish");
      $fatal(1, "timeout");
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && wb_ack) begin
         if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_ack: ack seen with no access outstanding");
         end else begin
            e = sb_q.pop_front();
            if (e.rd) begin
               checks++;
               if (wb_dat_o !== e.exp) begin
                  errors++;
                  $display("FAIL %s: read 0x%08h expected 0x%08h", e.name, wb_dat_o, e.exp);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus(input bit we, input logic [7:0] addr, input logic [31:0] data,
                      input logic [31:0] exp, input string name);
      exp_t e;
      bit got;
      e.name = name; e.exp = exp; e.rd = !we;
      @(negedge clk);
      sb_q.push_back(e);
      wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_dat_i = data;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         got = wb_ack;
      end
      wb_stb = 1'b0; wb_we = 1'b0;
      if (!got) begin
         checks++; errors++;
         $display("FAIL %s: no ack within 8 cycles, expected ack", name);
         sb_q.delete(sb_q.size() - 1);
      end
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] data);
      bus(1'b1, addr, data, '0, "write");
   endtask

   task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input string name);
      bus(1'b0, addr, '0, exp, name);
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // reset state
      wait_neg(3);
      chk("rst_ack", wb_ack, 0);
      chk("rst_dat", wb_dat_o, 0);
      chk("rst_irq", irq, 0);
      chk("rst_pwm", pwm_disable, 0);
      rst_n = 1'b1;
      rd(ENABLE, 32'h1F, "rst_enable");
      rd(FILTER, 32'd3, "rst_filter");
      rd(POL, 32'h0, "rst_pol");
      rd(IRQ_EN, 32'h0, "rst_irq_en");
      rd(WDT_TO, 32'd50_000_000, "rst_wdt_to");
      rd(LATCH, 32'h0, "rst_latch");
      rd(FIRST, 32'h0, "rst_first");
      wr(8'h24, 32'hFFFF_FFFF);
      rd(8'h24, 32'h0, "unmapped");
      wr(STATUS, 32'h1F);
      rd(STATUS, 32'h0, "status_ro");

      // 3-cycle glitch with FILTER=3 is rejected
      @(negedge clk); fault_in[0] = 1'b1;
      seen = 1'b0;
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk);
         if (j == 3) fault_in[0] = 1'b0;
         seen |= pwm_disable;
      end
      chk("glitch_pwm", seen, 0);
      rd(STATUS, 32'h0, "glitch_status");
      rd(LATCH, 32'h0, "glitch_latch");

      // 4-cycle pulse passes: pwm after edge 5, latch at 6, irq at 7
      wr(IRQ_EN, 32'h01);
      @(negedge clk); fault_in[0] = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         if (j == 4) fault_in[0] = 1'b0;
         if (j == 5) chk("hold_pwm_e4", pwm_disable, 0);
         if (j == 6) chk("hold_pwm_e5", pwm_disable, 1);
         if (j == 7) chk("hold_irq_e6", irq, 0);
         if (j == 8) chk("hold_irq_e7", irq, 1);
      end
      wait_neg(6);
      rd(STATUS, 32'h0, "hold_status_drop");
      rd(LATCH, 32'h1, "hold_latch");
      rd(FIRST, 32'h8000_0000, "hold_first");
      wr(LATCH, 32'h1);
      rd(LATCH, 32'h0, "hold_latch_clr");
      rd(FIRST, 32'h0, "hold_first_clr");
      chk("hold_pwm_clr", pwm_disable, 0);
      wr(IRQ_EN, 32'h0);

      // active-low channel 2 with FILTER=0, then masked by ENABLE
      wr(FILTER, 32'h0);
      wr(POL, 32'h4);
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         if (j == 3) chk("pol_pwm_e1", pwm_disable, 0);
         if (j == 4) chk("pol_pwm_e2", pwm_disable, 1);
      end
      rd(STATUS, 32'h4, "pol_status");
      rd(LATCH, 32'h4, "pol_latch");
      rd(FIRST, 32'h8000_0002, "pol_first");
      wr(ENABLE, 32'h1B);
      rd(STATUS, 32'h0, "pol_masked_status");
      rd(LATCH, 32'h4, "pol_masked_latch");
      chk("pol_masked_pwm", pwm_disable, 1);
      wr(LATCH, 32'h4);
      rd(LATCH, 32'h0, "pol_latch_clr");
      rd(FIRST, 32'h0, "pol_first_clr");
      chk("pol_pwm_clr", pwm_disable, 0);
      wr(POL, 32'h0);
      wait_neg(5);
      wr(ENABLE, 32'h1F);
      rd(STATUS, 32'h0, "pol_restored");

      // first fault is channel 3; W1C of live bits leaves them set
      @(negedge clk); fault_in[3] = 1'b1;
      wait_neg(10); fault_in[1] = 1'b1;
      wait_neg(10);
      rd(FIRST, 32'h8000_0003, "ff_first");
      rd(LATCH, 32'h0A, "ff_latch");
      rd(STATUS, 32'h0A, "ff_status");
      wr(IRQ_EN, 32'h02);
      @(negedge clk); chk("ff_irq_e0", irq, 0);
      @(negedge clk); chk("ff_irq_e1", irq, 1);
      wr(LATCH, 32'h1F);
      rd(LATCH, 32'h0A, "w1c_live");
      fault_in = '0;
      wait_neg(6);
      rd(STATUS, 32'h0, "ff_status_drop");
      rd(LATCH, 32'h0A, "ff_latch_sticky");
      wr(LATCH, 32'h1F);
      rd(LATCH, 32'h0, "ff_latch_clr");
      rd(FIRST, 32'h0, "ff_first_clr");
      wait_neg(2);
      chk("ff_irq_clr", irq, 0);

      // watchdog kicked in time, then starved
      wr(IRQ_EN, 32'h10);
      wr(WDT_TO, 32'd100);
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 85; j++) begin
            @(negedge clk);
            seen |= pwm_disable;
         end
         wr(KICK, KEY);
      end
      chk("wdt_kicked_pwm", seen, 0);
      for (int j = 1; j <= 104; j++) begin
         @(negedge clk);
         if (j == 101) chk("wdt_pwm_pre", pwm_disable, 0);
         if (j == 102) chk("wdt_pwm_exp", pwm_disable, 1);
         if (j == 103) chk("wdt_irq_pre", irq, 0);
         if (j == 104) chk("wdt_irq", irq, 1);
      end
      rd(LATCH, 32'h10, "wdt_latch");
      rd(STATUS, 32'h10, "wdt_status");
      rd(FIRST, 32'h8000_0004, "wdt_first");
      wr(KICK, KEY);
      wr(WDT_TO, 32'd1_000_000);
      wr(LATCH, 32'h10);
      rd(LATCH, 32'h0, "wdt_latch_clr");
      rd(STATUS, 32'h0, "wdt_status_clr");

      // bad key latches the watchdog source immediately
      wr(KICK, 32'h0000_1234);
      @(negedge clk);
      chk("badkey_pwm", pwm_disable, 1);
      chk("badkey_irq_e0", irq, 0);
      @(negedge clk);
      chk("badkey_irq_e1", irq, 1);
      rd(LATCH, 32'h10, "badkey_latch");
      rd(STATUS, 32'h0, "badkey_status");
      wr(LATCH, 32'h10);
      rd(LATCH, 32'h0, "badkey_clr");
      wr(ENABLE, 32'h0F);
      wr(KICK, 32'hDEAD_BEEF);
      rd(LATCH, 32'h10, "badkey_dis_latch");
      rd(STATUS, 32'h0, "badkey_dis_status");
      wr(LATCH, 32'h10);
      rd(LATCH, 32'h0, "badkey_dis_clr");
      wr(ENABLE, 32'h1F);

      // async reset during a held fault and a pending ack
      wr(IRQ_EN, 32'h01);
      @(negedge clk); fault_in[0] = 1'b1;
      wait_neg(6);
      chk("prerst_irq", irq, 1);
      chk("prerst_pwm", pwm_disable, 1);
      @(negedge clk);
      wb_stb = 1'b1; wb_we = 1'b0; wb_addr = LATCH;
      @(posedge clk); #2;
      chk("prerst_ack", wb_ack, 1);
      chk("prerst_dat", wb_dat_o, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_ack", wb_ack, 0);
      chk("rst_async_dat", wb_dat_o, 0);
      chk("rst_async_irq", irq, 0);
      chk("rst_async_pwm", pwm_disable, 0);
      wb_stb = 1'b0;
      wait_neg(3);
      rst_n = 1'b1;
      for (int j = 1; j <= 6; j++) begin
         @(negedge clk);
         if (j == 5) chk("relatch_pwm_e4", pwm_disable, 0);
         if (j == 6) chk("relatch_pwm_e5", pwm_disable, 1);
      end
      rd(LATCH, 32'h1, "relatch_latch");
      rd(FILTER, 32'd3, "relatch_filter");
      rd(FIRST, 32'h8000_0000, "relatch_first");
      fault_in = '0;

      wait_neg(3);
      chk("sb_drain", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
